alu_operand_queue: RTL and testbench

- Operand/opcode queue directly upstream of the combinational alu (IN_WIDTH operands, 3-bit opcode, 2*IN_WIDTH result).
- Buffers operation requests from the issuing logic with a valid/ready handshake.
- Presents the head entry on a, b and opcode, which connect straight to the alu inputs.
- Decouples the request rate from the alu consumer.

---
 rtl/alu_operand_queue.sv | 98 +++++++++
 tb/tb_alu_operand_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_queue.sv
// Show-ahead operand/opcode FIFO feeding the combinational alu inputs.
// Build option ALU_QUEUE_BYPASS_EN: an empty queue forwards a request to a/b/opcode in the same cycle.
module alu_operand_queue #(
    parameter int IN_WIDTH     = 4,
    parameter int OPCODE_WIDTH = 3,
    parameter int DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_WIDTH-1:0]        in_a,
    input  logic [IN_WIDTH-1:0]        in_b,
    input  logic [OPCODE_WIDTH-1:0]    in_opcode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IN_WIDTH-1:0]        a,
    output logic [IN_WIDTH-1:0]        b,
    output logic [OPCODE_WIDTH-1:0]    opcode,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = OPCODE_WIDTH + 2 * IN_WIDTH;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Entry layout: {opcode, a, b}
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_bypass_take;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_in_entry;
    logic [ENTRY_W-1:0] w_head;
    logic [ENTRY_W-1:0] w_out_entry;
    logic               w_out_valid;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_in_entry = {in_opcode, in_a, in_b};
    assign w_head     = r_mem[r_rd_ptr];

`ifdef ALU_QUEUE_BYPASS_EN
    // A request meeting an empty queue and a ready consumer retires without touching storage.
    assign w_bypass_take = w_empty && in_valid && out_ready;
    assign w_out_valid   = !w_empty || in_valid;
    assign w_out_entry   = !w_empty ? w_head :
                           (in_valid ? w_in_entry : '0);
`else
    assign w_bypass_take = 1'b0;
    assign w_out_valid   = !w_empty;
    assign w_out_entry   = !w_empty ? w_head : '0;
`endif

    // in_ready depends on stored state only, so a pop never frees a slot in the same cycle.
    assign w_push = in_valid && !w_full && !w_bypass_take;
    assign w_pop  = !w_empty && out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = w_out_valid;
    assign count     = r_count;
    assign opcode    = w_out_entry[ENTRY_W-1 -: OPCODE_WIDTH];
    assign a         = w_out_entry[2*IN_WIDTH-1 -: IN_WIDTH];
    assign b         = w_out_entry[IN_WIDTH-1:0];

endmodule

// File: tb/tb_alu_operand_queue.sv
// Directed bench for alu_operand_queue with a queue-based reference model checked every cycle.
module tb_alu_operand_queue;

    localparam int DEPTH = 4;
`ifdef ALU_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_opcode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] opcode;
    logic [2:0] count;

    int n_checks = 0;
    int n_errors = 0;

    alu_operand_queue #(.IN_WIDTH(4), .OPCODE_WIDTH(3), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .opcode(opcode), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {opcode, a, b} updated by the handshake rules.
    logic [10:0] mq[$];
    bit armed = 1'b0;

    always @(posedge clk) begin
        bit do_push, do_pop, byp_take;
        if (rst) begin
            mq.delete();
            armed = 1'b1;
        end else begin
            byp_take = BYP && (mq.size() == 0) && in_valid && out_ready;
            do_pop   = (mq.size() != 0) && out_ready;
            do_push  = in_valid && (mq.size() < DEPTH) && !byp_take;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({in_opcode, in_a, in_b});
        end
    end

    always @(negedge clk) begin
        logic [10:0] head;
        bit          ev;
        if (armed) begin
            if (mq.size() != 0) begin
                head = mq[0];
                ev   = 1'b1;
            end else if (BYP && in_valid) begin
                head = {in_opcode, in_a, in_b};
                ev   = 1'b1;
            end else begin
                head = '0;
                ev   = 1'b0;
            end
            check("cmp_count", 32'(count), 32'(mq.size()));
            check("cmp_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
            check("cmp_out_valid", 32'(out_valid), 32'(ev));
            check("cmp_a", 32'(a), 32'(head[7:4]));
            check("cmp_b", 32'(b), 32'(head[3:0]));
            check("cmp_opcode", 32'(opcode), 32'(head[10:8]));
        end
    end

    task automatic drive(input logic v, input int av, input int bv, input int ov, input logic ordy);
        in_valid  = v;
        in_a      = 4'(av);
        in_b      = 4'(bv);
        in_opcode = 3'(ov);
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string name, input int av, input int bv, input int ov);
        check({name, "_a"}, 32'(a), 32'(av));
        check({name, "_b"}, 32'(b), 32'(bv));
        check({name, "_op"}, 32'(opcode), 32'(ov));
    endtask

    int fill_a[4]  = '{3, 15, 7, 2};
    int fill_b[4]  = '{5, 1, 7, 9};
    int fill_op[4] = '{0, 1, 2, 4};

    initial begin
        rst = 1'b1;
        drive(1'b1, 9, 9, 7, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0);
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check_head("rst_head", 0, 0, 0);

        // Fill to full, then hold off a fifth request
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_a[i], fill_b[i], fill_op[i], 1'b0);
            tick();
        end
        check("full_count", 32'(count), 4);
        check("full_in_ready", 32'(in_ready), 0);
        check_head("full_head", 3, 5, 0);
        drive(1'b1, 1, 1, 3, 1'b0);
        tick();
        check("held_count", 32'(count), 4);

        // Full with a pop: only the pop happens this edge
        out_ready = 1'b1;
        tick();
        check("fullpop_count", 32'(count), 3);
        check_head("fullpop_head", 15, 1, 1);
        out_ready = 1'b0;
        tick();
        check("refill_count", 32'(count), 4);

        drive(1'b0, 0, 0, 0, 1'b1);
        tick();
        check_head("drain1", 7, 7, 2);
        tick();
        check_head("drain2", 2, 9, 4);
        tick();
        check_head("drain3", 1, 1, 3);
        tick();
        check("drained_count", 32'(count), 0);
        check("drained_valid", 32'(out_valid), 0);
        check_head("drained_head", 0, 0, 0);

        // Request on an empty queue: visible same cycle only with bypass
        drive(1'b1, 6, 2, 3, 1'b1);
        #1;
        check("empty_req_valid", 32'(out_valid), 32'(BYP));
`ifdef ALU_QUEUE_BYPASS_EN
        check_head("bypass_head", 6, 2, 3);
        check("bypass_count", 32'(count), 0);
`endif
        tick();
`ifdef ALU_QUEUE_BYPASS_EN
        check("bypass_after_count", 32'(count), 0);
`else
        check("nobyp_after_count", 32'(count), 1);
        check_head("nobyp_head", 6, 2, 3);
`endif
        drive(1'b0, 0, 0, 0, 1'b1);
        tick();

        // Wrap-around: push/pop pairs cross the pointer wrap several times
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i, 15 - i, i % 8, 1'b1);
            tick();
`ifndef ALU_QUEUE_BYPASS_EN
            check("wrap_count", 32'(count), 1);
            check_head("wrap_head", i, 15 - i, i % 8);
`endif
            drive(1'b0, 0, 0, 0, 1'b1);
            tick();
            check("wrap_empty", 32'(count), 0);
        end

        // Steady stream at count==1
        drive(1'b1, 8, 1, 6, 1'b0);
        tick();
        check_head("stream_seed", 8, 1, 6);
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, j, j + 2, j, 1'b1);
            tick();
            check("stream_count", 32'(count), 1);
            check("stream_valid", 32'(out_valid), 1);
            check_head("stream_head", j, j + 2, j);
        end
        drive(1'b0, 0, 0, 0, 1'b1);
        tick();

        // Reset in the middle of operation
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, k + 10, k, k, 1'b0);
            tick();
        end
        check("mid_count", 32'(count), 3);
        drive(1'b1, 12, 12, 1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0);
        check("midrst_count", 32'(count), 0);
        check("midrst_valid", 32'(out_valid), 0);
        drive(1'b1, 4, 4, 5, 1'b0);
        tick();
        drive(1'b0, 0, 0, 0, 1'b0);
        check("post_rst_count", 32'(count), 1);
        check_head("post_rst_head", 4, 4, 5);
        out_ready = 1'b1;
        tick();
        check("final_count", 32'(count), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
